// File: rtl/reg_desloc_n.sv
// Multi-mode shift register: loads an operand, then applies one single-bit
// shift/rotate/serial step per clock for a latched amount, pulsing done at the end.
module reg_desloc_n #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       mode,
    input  logic [SHW-1:0]   amount,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_n;
    logic [2:0]       mode_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic             accept;

    assign accept = (state == IDLE) && start;

    // One single-bit step of the latched mode; step_bit is the bit leaving out.
    always_comb begin
        step_val = out;
        step_bit = sout;
        case (mode_q)
            3'b001: begin step_val = {1'b0, out[WIDTH-1:1]};         step_bit = out[0];       end
            3'b010: begin step_val = {out[WIDTH-2:0], 1'b0};         step_bit = out[WIDTH-1]; end
            3'b011: begin step_val = {out[WIDTH-1], out[WIDTH-1:1]}; step_bit = out[0];       end
            3'b100: begin step_val = {out[0], out[WIDTH-1:1]};       step_bit = out[0];       end
            3'b101: begin step_val = {out[WIDTH-2:0], out[WIDTH-1]}; step_bit = out[WIDTH-1]; end
            3'b110: begin step_val = {sin, out[WIDTH-1:1]};          step_bit = out[0];       end
            3'b111: begin step_val = {out[WIDTH-2:0], sin};          step_bit = out[WIDTH-1]; end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = (amount == '0 || mode == 3'b000) ? FIN : RUN;
            RUN:  if (cnt == SHW'(1)) state_n = FIN;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // busy/done are registered from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out    <= '0;
            sout   <= 1'b0;
            cnt    <= '0;
            mode_q <= 3'b000;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            done <= (state_n == FIN);
            if (accept) begin
                out    <= data;
                sout   <= 1'b0;
                cnt    <= amount;
                mode_q <= mode;
            end else if (state == RUN) begin
                out  <= step_val;
                sout <= step_bit;
                cnt  <= cnt - SHW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_desloc_n.sv
// Scoreboard bench for reg_desloc_n: expected {sout,out} pushed at start,
// popped and compared whenever done is observed.
module tb_reg_desloc_n;

    localparam int W  = 8;
    localparam int SH = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  data;
    logic [2:0]    mode;
    logic [SH-1:0] amount;
    logic          sin;
    logic [W-1:0]  out;
    logic          sout;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [W:0]   sb[$];
    logic [W-1:0] last_out;

    reg_desloc_n #(.WIDTH(W), .SHW(SH)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .mode(mode),
        .amount(amount), .sin(sin), .out(out), .sout(sout), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] d, input logic [2:0] m,
                                         input logic [SH-1:0] a, input logic s);
        logic [W-1:0] v;
        logic b;
        v = d;
        b = 1'b0;
        if (m != 3'b000) begin
            for (int i = 0; i < int'(a); i++) begin
                case (m)
                    3'd1: begin b = v[0];   v = v >> 1; end
                    3'd2: begin b = v[W-1]; v = v << 1; end
                    3'd3: begin b = v[0];   v = W'($signed(v) >>> 1); end
                    3'd4: begin b = v[0];   v = (v >> 1) | (v << (W-1)); end
                    3'd5: begin b = v[W-1]; v = (v << 1) | (v >> (W-1)); end
                    3'd6: begin b = v[0];   v = (v >> 1) | (W'(s) << (W-1)); end
                    default: begin b = v[W-1]; v = (v << 1) | W'(s); end
                endcase
            end
        end
        return {b, v};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                chk("sb_out", 32'(out), 32'(e[W-1:0]));
                chk("sb_sout", 32'(sout), 32'(e[W]));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] d, input logic [2:0] m, input logic [SH-1:0] a,
                          input logic s, input logic use_exp, input logic [W-1:0] eo,
                          input logic eso, input logic poke);
        logic [W:0] e;
        int n, lat;
        bit seen;
        e = use_exp ? {eso, eo} : model(d, m, a, s);
        sb.push_back(e);
        lat = (a == 0 || m == 3'b000) ? 1 : int'(a) + 1;
        @(negedge clk);
        data = d; mode = m; amount = a; sin = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_run", 32'(busy), 1);
            if (poke && n == 2) begin
                data = 8'hFF; mode = 3'b010; amount = 3'd1; start = 1'b1;
            end
            if (poke && n == 3) start = 1'b0;
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 1);
        chk("latency", 32'(n), 32'(lat));
        @(negedge clk);
        chk("done_1cyc", 32'(done), 0);
        chk("busy_drop", 32'(busy), 0);
        last_out = e[W-1:0];
    endtask

    initial begin
        int ndone;
        rst = 1'b0; start = 1'b0; data = '0; mode = '0; amount = '0; sin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out), 0);
        chk("rst_sout", 32'(sout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b1;

        run_op(8'b1011_0110, 3'b001, 3'd3, 1'b0, 1, 8'b0001_0110, 1'b1, 0);
        run_op(8'b1001_0000, 3'b011, 3'd2, 1'b0, 1, 8'b1110_0100, 1'b0, 0);
        run_op(8'b1000_0001, 3'b101, 3'd1, 1'b0, 1, 8'b0000_0011, 1'b1, 0);
        run_op(8'h00,        3'b111, 3'd4, 1'b1, 1, 8'b0000_1111, 1'b0, 0);
        run_op(8'h00,        3'b110, 3'd4, 1'b1, 1, 8'b1111_0000, 1'b0, 0);
        run_op(8'hA5,        3'b000, 3'd5, 1'b0, 1, 8'hA5,        1'b0, 0);
        run_op(8'hA5,        3'b001, 3'd0, 1'b0, 1, 8'hA5,        1'b0, 0);
        run_op(8'b1011_0110, 3'b001, 3'd3, 1'b0, 1, 8'b0001_0110, 1'b1, 1);

        // idle with start low holds the result
        repeat (3) @(negedge clk);
        chk("idle_hold", 32'(out), 32'(last_out));

        // reset in the middle of a run
        @(negedge clk);
        data = 8'hFF; mode = 3'b001; amount = 3'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out", 32'(out), 0);
        chk("mrst_sout", 32'(sout), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        rst = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mrst_nodone", 32'(ndone), 0);

        for (int i = 0; i < 16; i++) begin
            run_op(W'($urandom), 3'($urandom_range(0, 7)), SH'($urandom_range(0, 7)),
                   1'($urandom), 0, '0, 1'b0, 0);
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
